// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low 7-segment bus back into packed BCD frames.
// Define SEG7_HEX_EN to also decode the hex glyphs A..F as nibbles 0xA..0xF.
module seg7_scan_reader #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
    output logic [4*NDIG-1:0]   out_data,
    output logic [NDIG-1:0]     out_dp,
    output logic [NDIG-1:0]     out_blank,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_ovf
);

    localparam int unsigned CW = $clog2(STABLE_CYC + 1);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned ZW = $clog2(NDIG + 1);
    localparam int unsigned SW = NDIG + 8;

    logic [7:0]        r_seg_s1, r_seg_s2;
    logic [NDIG-1:0]   r_an_s1, r_an_s2;
    logic [SW-1:0]     r_prev;
    logic [CW-1:0]     r_cnt;
    logic [NDIG-1:0]   r_mask;
    logic              r_err;
    logic              r_pend;
    logic [4*NDIG-1:0] r_slot_nib;
    logic [NDIG-1:0]   r_slot_dp;
    logic [NDIG-1:0]   r_slot_blank;
    logic [4*NDIG-1:0] r_out_data;
    logic [NDIG-1:0]   r_out_dp;
    logic [NDIG-1:0]   r_out_blank;
    logic              r_out_err;
    logic              r_out_valid;
    logic              r_out_ovf;

    logic [SW-1:0]     w_sample;
    logic [ZW-1:0]     w_nz;
    logic [IW-1:0]     w_idx;
    logic              w_dwell;
    logic              w_same;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_cap;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic              w_ill;
    logic [NDIG-1:0]   w_mask_cap;

    // Pattern decode: {illegal, blank, nibble}
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] r;
        r = {2'b00, 4'h0};
        case (p)
            7'h01: r[3:0] = 4'h0;
            7'h4F: r[3:0] = 4'h1;
            7'h12: r[3:0] = 4'h2;
            7'h06: r[3:0] = 4'h3;
            7'h4C: r[3:0] = 4'h4;
            7'h24: r[3:0] = 4'h5;
            7'h20: r[3:0] = 4'h6;
            7'h0F: r[3:0] = 4'h7;
            7'h00: r[3:0] = 4'h8;
            7'h04: r[3:0] = 4'h9;
`ifdef SEG7_HEX_EN
            7'h08: r[3:0] = 4'hA;
            7'h60: r[3:0] = 4'hB;
            7'h31: r[3:0] = 4'hC;
            7'h42: r[3:0] = 4'hD;
            7'h30: r[3:0] = 4'hE;
            7'h38: r[3:0] = 4'hF;
`endif
            7'h7F: r = {2'b01, 4'h0};
            default: r = {2'b10, 4'hF};
        endcase
        return r;
    endfunction

    // Two-flop synchronizers plus previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_an_s1  <= '0;
            r_an_s2  <= '0;
            r_prev   <= '0;
        end else begin
            r_seg_s1 <= seg_n;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_n;
            r_an_s2  <= r_an_s1;
            r_prev   <= w_sample;
        end
    end

    assign w_sample = {r_an_s2, r_seg_s2};
    assign w_same   = (w_sample == r_prev);

    // Count active anodes and locate the selected digit
    always_comb begin
        w_nz  = '0;
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!r_an_s2[i]) begin
                w_nz  = w_nz + ZW'(1);
                w_idx = IW'(i);
            end
        end
    end

    assign w_dwell = (w_nz == ZW'(1));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_dwell) begin
            w_cnt_nxt = '0;
        end else if (!w_same) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt < CW'(STABLE_CYC)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Capture only on the step into STABLE_CYC, so a held digit is taken once
    assign w_cap = w_dwell && w_same && (r_cnt == CW'(STABLE_CYC - 1));

    assign {w_ill, w_blank, w_nib} = f_decode(r_seg_s2[7:1]);
    assign w_mask_cap = r_mask | (NDIG'(1) << w_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Frame assembly slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_nib   <= '0;
            r_slot_dp    <= '0;
            r_slot_blank <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_cap && (w_idx == IW'(i))) begin
                    r_slot_nib[4*i +: 4] <= w_nib;
                    r_slot_dp[i]         <= ~r_seg_s2[0];
                    r_slot_blank[i]      <= w_blank;
                end
            end
        end
    end

    // Capture mask, error accumulator and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_err  <= 1'b0;
            r_pend <= 1'b0;
        end else if (r_pend) begin
            r_mask <= '0;
            r_err  <= 1'b0;
            r_pend <= 1'b0;
        end else if (w_cap) begin
            r_mask <= w_mask_cap;
            r_err  <= r_err | w_ill;
            r_pend <= &w_mask_cap;
        end
    end

    // Output register slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_dp    <= '0;
            r_out_blank <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_ovf <= 1'b0;
            if (r_pend) begin
                if (!r_out_valid || out_ready) begin
                    r_out_data  <= r_slot_nib;
                    r_out_dp    <= r_slot_dp;
                    r_out_blank <= r_slot_blank;
                    r_out_err   <= r_err;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_ovf <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_dp    = r_out_dp;
    assign out_blank = r_out_blank;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: run-length reference model plus literal frame checks.
module tb_seg7_scan_reader;

    localparam int NDIG = 4;
    localparam int S    = 4;
    localparam int HD   = S + 3;

    logic              clk;
    logic              rst_n;
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] out_data;
    logic [NDIG-1:0]   out_dp;
    logic [NDIG-1:0]   out_blank;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;
    logic              out_ovf;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .out_data(out_data), .out_dp(out_dp), .out_blank(out_blank),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph table: index is the nibble, value is seg_n[7:1]
    localparam logic [6:0] PAT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    task automatic model_dec(input logic [6:0] p, output logic [3:0] nib,
                             output logic bl, output logic ill);
        int lim;
`ifdef SEG7_HEX_EN
        lim = 16;
`else
        lim = 10;
`endif
        nib = 4'hF; bl = 1'b0; ill = 1'b1;
        if (p == 7'h7F) begin
            nib = 4'h0; bl = 1'b1; ill = 1'b0;
        end else begin
            for (int k = 0; k < lim; k++)
                if (PAT[k] == p) begin nib = 4'(k); ill = 1'b0; end
        end
    endtask

    // Reference model: a digit is taken when the delayed input history shows exactly S equal dwell samples
    logic [11:0] hist[$];
    logic [3:0]  m_nib [NDIG];
    logic [NDIG-1:0] m_sdp, m_sbl, m_mask, m_dp, m_blank;
    logic        m_err, m_pend, m_valid, m_ferr, m_ovf;
    logic [15:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        logic [11:0] s;
        int run, idx;
        logic [3:0] nib;
        logic bl, ill;
        if (!rst_n) begin
            hist.delete();
            for (int j = 0; j < HD; j++) hist.push_back(12'h000);
            for (int j = 0; j < NDIG; j++) m_nib[j] = 4'h0;
            m_sdp = '0; m_sbl = '0; m_mask = '0; m_dp = '0; m_blank = '0;
            m_err = 0; m_pend = 0; m_valid = 0; m_ferr = 0; m_ovf = 0; m_data = '0;
        end else begin
            m_ovf = 1'b0;
            hist.push_front({an_n, seg_n});
            if (hist.size() > HD) void'(hist.pop_back());
            if (m_pend) begin
                if (!m_valid || out_ready) begin
                    m_valid = 1'b1;
                    for (int j = 0; j < NDIG; j++) m_data[4*j +: 4] = m_nib[j];
                    m_dp = m_sdp; m_blank = m_sbl; m_ferr = m_err;
                end else begin
                    m_ovf = 1'b1;
                end
                m_mask = '0; m_err = 1'b0; m_pend = 1'b0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            s = hist[2];
            run = 0;
            for (int j = 2; j < HD; j++) begin
                if (hist[j] != s) break;
                run++;
            end
            if ($countones(~s[11:8]) == 1 && run == S) begin
                idx = 0;
                for (int j = 0; j < NDIG; j++) if (!s[8+j]) idx = j;
                model_dec(s[7:1], nib, bl, ill);
                m_nib[idx] = nib; m_sdp[idx] = ~s[0]; m_sbl[idx] = bl;
                m_mask[idx] = 1'b1;
                m_err = m_err | ill;
                if (&m_mask) m_pend = 1'b1;
            end
        end
    end

    // Cycle compare against the model, plus observed-frame bookkeeping
    int n_frames = 0, n_ovf = 0, n_vhi = 0;
    logic [15:0] acc_data;
    logic [3:0]  acc_dp, acc_blank;
    logic        acc_err;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(out_valid), 32'(m_valid));
            chk("ovf",   32'(out_ovf),   32'(m_ovf));
            chk("data",  32'(out_data),  32'(m_data));
            chk("dp",    32'(out_dp),    32'(m_dp));
            chk("blank", 32'(out_blank), 32'(m_blank));
            chk("err",   32'(out_err),   32'(m_ferr));
            if (out_valid) n_vhi++;
            if (out_ovf) n_ovf++;
            if (out_valid && out_ready) begin
                n_frames++;
                acc_data = out_data; acc_dp = out_dp;
                acc_blank = out_blank; acc_err = out_err;
            end
        end
    end

    task automatic show(input int d, input logic [7:0] seg, input int n);
        an_n  = ~(NDIG'(1) << d);
        seg_n = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [7:0] s3, input logic [7:0] s2,
                         input logic [7:0] s1, input logic [7:0] s0);
        show(3, s3, 8); show(2, s2, 8); show(1, s1, 8); show(0, s0, 8);
    endtask

    localparam logic [7:0] G0 = 8'h03, G1 = 8'h9F, G2 = 8'h25, G3 = 8'h0D, G4 = 8'h99,
                           G5 = 8'h49, G6 = 8'h41, G7 = 8'h1F, G8 = 8'h01, G9 = 8'h09;

    int f0, o0, v0;

    initial begin
        rst_n = 1'b0; an_n = '1; seg_n = '1; out_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_ovf",   32'(out_ovf),   32'h0);
        chk("rst_err",   32'(out_err),   32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Basic scan 1,2,3,4
        f0 = n_frames; v0 = n_vhi;
        scan4(G1, G2, G3, G4); idle(6);
        chk("t1_frames", 32'(n_frames - f0), 32'd1);
        chk("t1_data",   32'(acc_data), 32'h1234);
        chk("t1_err",    32'(acc_err),  32'h0);
        chk("t1_vpulse", 32'(n_vhi - v0), 32'd1);

        // Short dwell on digit 2 is ignored until it is held long enough
        f0 = n_frames;
        show(3, G5, 8); show(2, G6, S - 1); show(1, G7, 8); show(0, G8, 8); idle(6);
        chk("t2_noframe", 32'(n_frames - f0), 32'd0);
        show(2, G6, 8); idle(6);
        chk("t2_frames", 32'(n_frames - f0), 32'd1);
        chk("t2_data",   32'(acc_data), 32'h5678);

        // Overlapping anodes capture nothing and leave the mask alone
        f0 = n_frames;
        show(3, G9, 8); show(2, G0, 8);
        an_n = 4'b1100; seg_n = G4; idle(10);
        chk("t3_noframe", 32'(n_frames - f0), 32'd0);
        show(1, G1, 8); show(0, G2, 8); idle(6);
        chk("t3_frames", 32'(n_frames - f0), 32'd1);
        chk("t3_data",   32'(acc_data), 32'h9012);

        // Blank digit and decimal point
        scan4(G1, G2, 8'h02, 8'hFF); idle(6);
        chk("t4_data",  32'(acc_data),  32'h1200);
        chk("t4_blank", 32'(acc_blank), 32'h1);
        chk("t4_dp",    32'(acc_dp),    32'h2);
        chk("t4_err",   32'(acc_err),   32'h0);

        // Hex glyph A
        scan4(G1, G1, 8'h11, G1); idle(6);
`ifdef SEG7_HEX_EN
        chk("t5_data", 32'(acc_data), 32'h11A1);
        chk("t5_err",  32'(acc_err),  32'h0);
`else
        chk("t5_data", 32'(acc_data), 32'h11F1);
        chk("t5_err",  32'(acc_err),  32'h1);
`endif

        // Backpressure: second frame dropped, first held
        f0 = n_frames; o0 = n_ovf;
        out_ready = 1'b0;
        scan4(G1, G2, G3, G4); scan4(G5, G6, G7, G8); idle(6);
        chk("t6_ovf",   32'(n_ovf - o0), 32'd1);
        chk("t6_hold",  32'(out_valid),  32'h1);
        chk("t6_hdata", 32'(out_data),   32'h1234);
        out_ready = 1'b1; idle(3);
        chk("t6_frames", 32'(n_frames - f0), 32'd1);
        chk("t6_acc",    32'(acc_data), 32'h1234);
        chk("t6_vlow",   32'(out_valid), 32'h0);

        // Reset mid-frame discards the partial frame
        f0 = n_frames; o0 = n_ovf;
        show(3, G5, 8); show(2, G6, 8);
        an_n = '1; seg_n = '1; idle(1);
        rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(2);
        show(1, G3, 8); show(0, G4, 8); idle(6);
        chk("t7_noframe", 32'(n_frames - f0), 32'd0);
        show(3, G1, 8); show(2, G2, 8); idle(6);
        chk("t7_frames", 32'(n_frames - f0), 32'd1);
        chk("t7_data",   32'(acc_data), 32'h1234);
        chk("t7_noovf",  32'(n_ovf - o0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
